// File: rtl/raster_cmd_scheduler.sv
// Two-port round-robin command scheduler feeding the 8x8 rasterizer.
// Queues packed draw commands and paces issue on frame_sync plus pixel drain.
module raster_cmd_scheduler #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned DRAIN_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [19:0]              req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [19:0]              req1_data,
  output logic [1:0]               cmd,
  output logic [2:0]               x1,
  output logic [2:0]               y1,
  output logic [2:0]               x2,
  output logic [2:0]               y2,
  output logic [2:0]               width,
  output logic [2:0]               height,
  input  logic                     frame_sync,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sync_err,
  input  logic                     err_clr
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TMAX  = (DRAIN_CYCLES > SYNC_TIMEOUT) ? DRAIN_CYCLES : SYNC_TIMEOUT;
  localparam int unsigned TW    = $clog2(TMAX) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [17:0]   fields_q, fields_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          last1_q, last1_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [19:0]   mem_q [DEPTH];

  logic          full, empty;
  logic          grant0, grant1;
  logic          push, pop;
  logic [19:0]   push_data;
  logic [19:0]   head;
  logic          set_err;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Round-robin arbiter: on contention the port not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full) begin
      if (req0_valid && req1_valid) begin
        grant0 = last1_q;
        grant1 = !last1_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;

  always_comb begin
    push      = 1'b0;
    push_data = req0_data;
    last1_d   = last1_q;
    if (grant0 && req0_valid) begin
      push    = 1'b1;
      last1_d = 1'b0;
    end else if (grant1 && req1_valid) begin
      push      = 1'b1;
      push_data = req1_data;
      last1_d   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = 2'b00;
    fields_d = fields_q;
    pop      = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // NOP entries are consumed without touching the rasterizer.
          if (head[19:18] != 2'b00) begin
            cmd_d    = head[19:18];
            fields_d = head[17:0];
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (frame_sync) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == TW'(DRAIN_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    busy_d   = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= 2'b00;
      fields_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      last1_q  <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      fields_q <= fields_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      last1_q  <= last1_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign cmd        = cmd_q;
  assign x1         = fields_q[17:15];
  assign y1         = fields_q[14:12];
  assign x2         = fields_q[11:9];
  assign y2         = fields_q[8:6];
  assign width      = fields_q[5:3];
  assign height     = fields_q[2:0];
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Bench for raster_cmd_scheduler: timeline-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_raster_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int SYNC_TIMEOUT = 8;
  localparam int DRAIN_CYCLES = 64;
  localparam int NEVER = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [19:0] req0_data = '0, req1_data = '0;
  logic [1:0] cmd;
  logic [2:0] x1, y1, x2, y2, width, height;
  logic frame_sync = 1'b0;
  logic busy;
  logic [2:0] fifo_count;
  logic sync_err;
  logic err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  raster_cmd_scheduler #(.DEPTH(DEPTH), .SYNC_TIMEOUT(SYNC_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .cmd(cmd), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .width(width), .height(height),
    .frame_sync(frame_sync), .busy(busy), .fifo_count(fifo_count),
    .sync_err(sync_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  function automatic void arb(input int sz, input logic v0, input logic v1, input bit l1,
                              output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (sz < DEPTH) begin
      if (v0 && v1) begin
        g0 = l1;
        g1 = !l1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
  endfunction

  // Reference model: a queue plus an edge timeline. avail is the first edge at
  // which the scheduler may take a new command; waiting marks an open sync window.
  logic [19:0] mq[$];
  int n = 0;
  int avail = 0;
  int iss_e = 0;
  bit waiting = 1'b0;
  bit last1 = 1'b1;
  logic [1:0] e_cmd = 2'b00;
  logic [17:0] e_f = '0;
  bit e_err = 1'b0;
  bit e_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      n = 0; avail = 0; iss_e = 0; waiting = 1'b0; last1 = 1'b1;
      e_cmd = 2'b00; e_f = '0; e_err = 1'b0; e_busy = 1'b0;
    end else begin
      bit g0, g1, to;
      logic [19:0] pd;
      n++;
      arb(mq.size(), req0_valid, req1_valid, last1, g0, g1);
      to = 1'b0;
      e_cmd = 2'b00;
      if (waiting) begin
        if (n >= iss_e + 2) begin
          if (frame_sync) begin
            waiting = 1'b0;
            avail = n + DRAIN_CYCLES + 1;
          end else if (n == iss_e + 1 + SYNC_TIMEOUT) begin
            waiting = 1'b0;
            avail = n + 1;
            to = 1'b1;
          end
        end
      end else if (n >= avail && mq.size() > 0) begin
        pd = mq.pop_front();
        if (pd[19:18] != 2'b00) begin
          e_cmd = pd[19:18];
          e_f = pd[17:0];
          iss_e = n;
          waiting = 1'b1;
          avail = NEVER;
        end
      end
      if (g0 && req0_valid) begin
        mq.push_back(req0_data);
        last1 = 1'b0;
      end else if (g1 && req1_valid) begin
        mq.push_back(req1_data);
        last1 = 1'b1;
      end
      if (to) e_err = 1'b1;
      else if (err_clr) e_err = 1'b0;
      e_busy = (n + 1 < avail) || (mq.size() != 0);
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit g0, g1;
    arb(mq.size(), req0_valid, req1_valid, last1, g0, g1);
    chk("cmd", 32'(cmd), 32'(e_cmd));
    chk("fields", 32'({x1, y1, x2, y2, width, height}), 32'(e_f));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("sync_err", 32'(sync_err), 32'(e_err));
    chk("req0_ready", 32'(req0_ready), 32'(rst_n & g0));
    chk("req1_ready", 32'(req1_ready), 32'(rst_n & g1));
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  logic [19:0] pulses[$];
  int ptime[$];
  always @(negedge clk) begin
    if (cmd != 2'b00) begin
      pulses.push_back({cmd, x1, y1, x2, y2, width, height});
      ptime.push_back(cyc_n);
    end
  end

  // Rasterizer stand-in: 0 = sync in second wait cycle, 1 = never, 2 = random.
  int rsmode = 0;
  int since = 1000;
  always @(posedge clk) begin
    #1;
    if (cmd != 2'b00) since = 0;
    else if (since < 1000) since++;
    case (rsmode)
      0: frame_sync = (since == 2);
      1: frame_sync = 1'b0;
      default: frame_sync = ($urandom_range(0, 9) < 3);
    endcase
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int p, input logic [19:0] d);
    int k;
    k = 0;
    if (p == 0) begin req0_valid = 1'b1; req0_data = d; end
    else begin req1_valid = 1'b1; req1_data = d; end
    #1;
    while (!((p == 0) ? req0_ready : req1_ready) && k < 300) begin
      cyc(1);
      k++;
    end
    chk("push_wait", 32'(k < 300), 32'd1);
    cyc(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((busy || fifo_count != 0) && k < bound) begin
      cyc(1);
      k++;
    end
    chk("idle_wait", 32'(k < bound), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] c0[6], c1[6], exp_iss[$], fl[$];
    int glog[$];
    int i0, i1, k, t0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);
    chk("lit_rst_cmd", 32'(cmd), 32'd0);
    chk("lit_rst_count", 32'(fifo_count), 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_err", 32'(sync_err), 32'd0);

    // Single command then a queued second one: 1-cycle latency, 68-cycle pacing.
    pulses.delete(); ptime.delete();
    push(0, 20'h5_2000);
    t0 = cyc_n;
    chk("lit_single_count", 32'(fifo_count), 32'd1);
    chk("lit_single_cmd_pre", 32'(cmd), 32'd0);
    push(0, 20'h6_4921);
    chk("lit_single_pulse", 32'(cmd), 32'd1);
    chk("lit_single_fields", 32'({x1, y1, x2, y2, width, height}), 32'h1_2000);
    chk("lit_single_lat", 32'(cyc_n - t0), 32'd1);
    cyc(1);
    chk("lit_single_cmd_post", 32'(cmd), 32'd0);
    wait_idle(500);
    chk("lit_single_npulse", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) begin
      chk("lit_b2b_gap", 32'(ptime[1] - ptime[0]), 32'd68);
      chk("lit_drain_end", 32'(cyc_n - ptime[1]), 32'd67);
      chk("lit_second_data", 32'(pulses[1]), 32'h6_4921);
    end

    // NOP filtering.
    pulses.delete(); ptime.delete();
    push(0, 20'h0_1234);
    t0 = cyc_n;
    push(0, 20'b11_010_011_000_000_100_010);
    wait_idle(500);
    chk("lit_nop_npulse", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1) begin
      chk("lit_nop_data", 32'(pulses[0]), 32'(20'b11_010_011_000_000_100_010));
      chk("lit_nop_gap", 32'(ptime[0] - t0), 32'd2);
    end

    // Timeout coinciding with err_clr: set wins, clear applies a cycle later.
    rsmode = 1;
    err_clr = 1'b1;
    pulses.delete(); ptime.delete();
    push(1, 20'h9_0000);
    k = 0;
    while (!sync_err && k < 100) begin cyc(1); k++; end
    chk("lit_to_seen", 32'(sync_err), 32'd1);
    if (ptime.size() == 1) chk("lit_to_time", 32'(cyc_n - ptime[0]), 32'd9);
    cyc(1);
    chk("lit_to_clr", 32'(sync_err), 32'd0);
    err_clr = 1'b0;
    wait_idle(200);

    // FIFO full with stalled frame_sync.
    pulses.delete(); ptime.delete(); fl.delete();
    for (int i = 0; i < DEPTH + 2; i++) fl.push_back({2'(1 + i % 3), 3'(i), 15'($urandom)});
    for (int i = 0; i < DEPTH + 1; i++) push(1, fl[i]);
    chk("lit_full_count", 32'(fifo_count), 32'd4);
    req1_valid = 1'b1; req1_data = fl[DEPTH + 1];
    #1;
    chk("lit_full_ready1", 32'(req1_ready), 32'd0);
    push(1, fl[DEPTH + 1]);
    wait_idle(300);
    chk("lit_full_err", 32'(sync_err), 32'd1);
    chk("lit_full_npulse", 32'(pulses.size()), 32'(DEPTH + 2));
    for (int i = 0; i < DEPTH + 2 && i < pulses.size(); i++) chk("lit_full_data", 32'(pulses[i]), 32'(fl[i]));
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("lit_full_clr", 32'(sync_err), 32'd0);

    // Arbitration with both ports continuously valid.
    rsmode = 0;
    for (int i = 0; i < 6; i++) begin
      c0[i] = {2'(1 + i % 3), 3'(i), 3'd0, 12'($urandom)};
      c1[i] = {2'(1 + (i + 1) % 3), 3'(i), 3'd1, 12'($urandom)};
    end
    pulses.delete(); ptime.delete(); glog.delete(); exp_iss.delete();
    i0 = 0; i1 = 0; k = 0;
    while ((i0 < 6 || i1 < 6) && k < 3000) begin
      req0_valid = (i0 < 6); req0_data = c0[(i0 < 6) ? i0 : 5];
      req1_valid = (i1 < 6); req1_data = c1[(i1 < 6) ? i1 : 5];
      #1;
      if (req0_valid && req0_ready) begin glog.push_back(0); exp_iss.push_back(c0[i0]); i0++; end
      else if (req1_valid && req1_ready) begin glog.push_back(1); exp_iss.push_back(c1[i1]); i1++; end
      cyc(1);
      k++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(500);
    chk("lit_arb_ngrant", 32'(glog.size()), 32'd12);
    for (int j = 0; j < glog.size(); j++) chk("lit_arb_order", 32'(glog[j]), 32'(j % 2));
    chk("lit_arb_npulse", 32'(pulses.size()), 32'd12);
    for (int j = 0; j < exp_iss.size() && j < pulses.size(); j++) chk("lit_arb_issue", 32'(pulses[j]), 32'(exp_iss[j]));

    // Reset in the middle of DRAIN with three entries queued.
    for (int i = 0; i < 4; i++) push(0, {2'b10, 3'(i), 15'h0});
    chk("lit_pre_rst_count", 32'(fifo_count), 32'd3);
    cyc(10);
    req0_valid = 1'b1; req0_data = 20'h4_0001;
    req1_valid = 1'b1; req1_data = 20'h8_0002;
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_mid_cmd", 32'(cmd), 32'd0);
    chk("lit_rst_mid_count", 32'(fifo_count), 32'd0);
    chk("lit_rst_mid_busy", 32'(busy), 32'd0);
    chk("lit_rst_mid_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    cyc(2);
    chk("lit_rst_hold_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("lit_post_rst_rdy", 32'({req0_ready, req1_ready}), 32'b10);
    cyc(1);
    chk("lit_post_rst_count", 32'(fifo_count), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(500);

    // Randomized traffic against the model.
    rsmode = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rsmode = $urandom_range(0, 2);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data = 20'($urandom);
      req1_data = 20'($urandom);
      err_clr = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; err_clr = 1'b0;
    rsmode = 0;
    wait_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
